// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD time-of-day clock with a programmable
// prescaler, NUM_ALARMS alarm slots, an IDLE/RINGING/SNOOZE ring controller,
// 12/24-hour display formatting and active-high 7-segment decoding.
module multi_alarm_clock #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int NUM_ALARMS    = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int RING_SEC      = 60,
  localparam int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_time,
  input  logic [23:0]      set_val,
  input  logic             alm_wr,
  input  logic [IDX_W-1:0] alm_idx,
  input  logic [16:0]      alm_val,
  input  logic             snooze,
  input  logic             dismiss,
  input  logic             mode12,
  output logic [3:0]       secU,
  output logic [3:0]       secT,
  output logic [3:0]       minU,
  output logic [3:0]       minT,
  output logic [3:0]       hrU,
  output logic [3:0]       hrT,
  output logic [6:0]       secUSeg,
  output logic [6:0]       secTSeg,
  output logic [6:0]       minUSeg,
  output logic [6:0]       minTSeg,
  output logic [6:0]       hrUSeg,
  output logic [6:0]       hrTSeg,
  output logic             pm,
  output logic             tick,
  output logic             ringing,
  output logic [IDX_W-1:0] ring_id
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    RING_LOAD  = 8'(RING_SEC);
  localparam logic [11:0]   SNZ_LOAD   = 12'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  // BCD hour pair {tens, units} is a legal 24-hour value 00..23
  function automatic logic hour_ok(input logic [7:0] h);
    return ((h[7:4] <= 4'd1) && (h[3:0] <= 4'd9)) ||
           ((h[7:4] == 4'd2) && (h[3:0] <= 4'd3));
  endfunction

  // BCD {hrT,hrU,minT,minU} is a legal hour:minute
  function automatic logic hm_ok(input logic [15:0] hm);
    return hour_ok(hm[15:8]) && (hm[7:4] <= 4'd5) && (hm[3:0] <= 4'd9);
  endfunction

  // BCD {hrT,hrU,minT,minU,secT,secU} is a legal time of day
  function automatic logic time_ok(input logic [23:0] t);
    return hm_ok(t[23:8]) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // advance a legal BCD time by one second, wrapping 23:59:59 to 00:00:00
  function automatic logic [23:0] next_second(input logic [23:0] t);
    logic [3:0] ht, hu, mt, mu, st, su;
    {ht, hu, mt, mu, st, su} = t;
    if (su != 4'd9) begin
      su = su + 4'd1;
    end else begin
      su = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if (mu != 4'd9) begin
          mu = mu + 4'd1;
        end else begin
          mu = 4'd0;
          if (mt != 4'd5) begin
            mt = mt + 4'd1;
          end else begin
            mt = 4'd0;
            if ((ht == 4'd2) && (hu == 4'd3)) begin
              ht = 4'd0;
              hu = 4'd0;
            end else if (hu == 4'd9) begin
              ht = ht + 4'd1;
              hu = 4'd0;
            end else begin
              hu = hu + 4'd1;
            end
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  // active-high {g,f,e,d,c,b,a} pattern for one decimal digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [PW-1:0]    presc_r;
  logic [23:0]      time_r;
  logic             tick_r;
  logic             alm_en_r [NUM_ALARMS];
  logic [15:0]      alm_hm_r [NUM_ALARMS];
  state_t           state_r, state_nxt;
  logic [7:0]       ring_tmr_r, ring_tmr_nxt;
  logic [11:0]      snz_tmr_r, snz_tmr_nxt;
  logic [IDX_W-1:0] ring_id_r, ring_id_nxt;

  logic             set_ok_s;
  logic             adv_s;
  logic [23:0]      time_nxt_s;
  logic             hit_s;
  logic [IDX_W-1:0] win_s;
  logic             match_s;
  logic [4:0]       hr_bin_s;
  logic [4:0]       hr_disp_s;
  logic [3:0]       hr_t_s, hr_u_s;
  logic             pm_s;

  // a valid load wins over the prescaler wrap; an invalid load is ignored
  assign set_ok_s = set_time && time_ok(set_val);
  assign adv_s    = (presc_r == PRESC_LAST) && !set_ok_s;

  // prescaler, time-of-day register and registered one-cycle tick
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      time_r  <= 24'h000000;
      tick_r  <= 1'b0;
    end else if (set_ok_s) begin
      presc_r <= '0;
      time_r  <= set_val;
      tick_r  <= 1'b0;
    end else if (adv_s) begin
      presc_r <= '0;
      time_r  <= time_nxt_s;
      tick_r  <= 1'b1;
    end else begin
      presc_r <= presc_r + PW'(1);
      tick_r  <= 1'b0;
    end
  end

  // alarm slot storage; illegal values and nonexistent slots are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_en_r[i] <= 1'b0;
        alm_hm_r[i] <= 16'h0000;
      end
    end else if (alm_wr && hm_ok(alm_val[15:0])) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alm_idx == IDX_W'(i)) begin
          alm_en_r[i] <= alm_val[16];
          alm_hm_r[i] <= alm_val[15:0];
        end
      end
    end
  end

  // alarm match on the tick that lands on HH:MM:00; lowest slot index wins
  always_comb begin
    time_nxt_s = next_second(time_r);
    hit_s      = 1'b0;
    win_s      = {IDX_W{1'b0}};
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alm_en_r[i] && (alm_hm_r[i] == time_nxt_s[23:8])) begin
        hit_s = 1'b1;
        win_s = IDX_W'(i);
      end else begin
        hit_s = hit_s;
        win_s = win_s;
      end
    end
    match_s = adv_s && (time_nxt_s[7:0] == 8'h00) && hit_s;
  end

  // ring controller state, timers and latched slot id
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ring_tmr_r <= 8'd0;
      snz_tmr_r  <= 12'd0;
      ring_id_r  <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_nxt;
      ring_tmr_r <= ring_tmr_nxt;
      snz_tmr_r  <= snz_tmr_nxt;
      ring_id_r  <= ring_id_nxt;
    end
  end

  // ring controller next state; dismiss always beats snooze
  always_comb begin
    state_nxt    = state_r;
    ring_tmr_nxt = ring_tmr_r;
    snz_tmr_nxt  = snz_tmr_r;
    ring_id_nxt  = ring_id_r;
    case (state_r)
      ST_IDLE: begin
        if (match_s) begin
          state_nxt    = ST_RINGING;
          ring_id_nxt  = win_s;
          ring_tmr_nxt = RING_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RINGING: begin
        if (dismiss) begin
          state_nxt    = ST_IDLE;
          ring_tmr_nxt = 8'd0;
        end else if (snooze) begin
          state_nxt    = ST_SNOOZE;
          ring_tmr_nxt = 8'd0;
          snz_tmr_nxt  = SNZ_LOAD;
        end else if (adv_s) begin
          if (ring_tmr_r <= 8'd1) begin
            state_nxt    = ST_IDLE;
            ring_tmr_nxt = 8'd0;
          end else begin
            ring_tmr_nxt = ring_tmr_r - 8'd1;
          end
        end else begin
          state_nxt = ST_RINGING;
        end
      end
      ST_SNOOZE: begin
        if (dismiss) begin
          state_nxt   = ST_IDLE;
          snz_tmr_nxt = 12'd0;
        end else if (adv_s) begin
          if (snz_tmr_r <= 12'd1) begin
            state_nxt    = ST_RINGING;
            snz_tmr_nxt  = 12'd0;
            ring_tmr_nxt = RING_LOAD;
          end else begin
            snz_tmr_nxt = snz_tmr_r - 12'd1;
          end
        end else begin
          state_nxt = ST_SNOOZE;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        ring_tmr_nxt = 8'd0;
        snz_tmr_nxt  = 12'd0;
      end
    endcase
  end

  // hour display: 24-hour BCD passthrough or 12-hour with pm flag
  always_comb begin
    hr_bin_s  = 5'(time_r[23:20]) * 5'd10 + 5'(time_r[19:16]);
    hr_disp_s = hr_bin_s;
    hr_t_s    = time_r[23:20];
    hr_u_s    = time_r[19:16];
    pm_s      = 1'b0;
    if (mode12) begin
      if (hr_bin_s == 5'd0) begin
        hr_disp_s = 5'd12;
      end else if (hr_bin_s > 5'd12) begin
        hr_disp_s = hr_bin_s - 5'd12;
      end else begin
        hr_disp_s = hr_bin_s;
      end
      pm_s = (hr_bin_s >= 5'd12);
      if (hr_disp_s >= 5'd10) begin
        hr_t_s = 4'd1;
        hr_u_s = 4'(hr_disp_s - 5'd10);
      end else begin
        hr_t_s = 4'd0;
        hr_u_s = hr_disp_s[3:0];
      end
    end else begin
      pm_s = 1'b0;
    end
  end

  assign secU    = time_r[3:0];
  assign secT    = time_r[7:4];
  assign minU    = time_r[11:8];
  assign minT    = time_r[15:12];
  assign hrU     = hr_u_s;
  assign hrT     = hr_t_s;
  assign pm      = pm_s;
  assign secUSeg = seg7(secU);
  assign secTSeg = seg7(secT);
  assign minUSeg = seg7(minU);
  assign minTSeg = seg7(minT);
  assign hrUSeg  = seg7(hr_u_s);
  assign hrTSeg  = seg7(hr_t_s);
  assign tick    = tick_r;
  assign ringing = (state_r == ST_RINGING);
  assign ring_id = ring_id_r;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: directed plus randomized stimulus for the alarm clock,
// checked every cycle against a seconds-since-midnight reference model.
module tb_multi_alarm_clock;

  localparam int TPS = 4;
  localparam int NA  = 4;
  localparam int SM  = 1;
  localparam int RS  = 3;

  logic        clk = 1'b0;
  logic        reset, set_time, alm_wr, snooze, dismiss, mode12;
  logic [23:0] set_val;
  logic [1:0]  alm_idx;
  logic [16:0] alm_val;
  logic [3:0]  secU, secT, minU, minT, hrU, hrT;
  logic [6:0]  secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg;
  logic        pm, tick, ringing;
  logic [1:0]  ring_id;

  multi_alarm_clock #(
    .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_SEC(RS)
  ) dut (
    .clk(clk), .reset(reset), .set_time(set_time), .set_val(set_val),
    .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_val(alm_val),
    .snooze(snooze), .dismiss(dismiss), .mode12(mode12),
    .secU(secU), .secT(secT), .minU(minU), .minT(minT), .hrU(hrU), .hrT(hrT),
    .secUSeg(secUSeg), .secTSeg(secTSeg), .minUSeg(minUSeg),
    .minTSeg(minTSeg), .hrUSeg(hrUSeg), .hrTSeg(hrTSeg),
    .pm(pm), .tick(tick), .ringing(ringing), .ring_id(ring_id)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  // reference model: time as seconds since midnight, alarms as minute of day
  int m_sec, m_pre, m_mode, m_id, m_rt, m_st;   // m_mode: 0 idle, 1 ringing, 2 snoozed
  bit m_tick;
  bit m_en [NA];
  int m_amin [NA];
  logic [6:0] seg_tab [10];

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  // apply the inputs present at this clock edge to the model
  task automatic model_edge();
    int sh, smn, ss, ah, am, nsec, win;
    bit set_ok, adv, match, dig_ok;
    if (reset) begin
      m_sec = 0; m_pre = 0; m_mode = 0; m_id = 0; m_rt = 0; m_st = 0; m_tick = 0;
      for (int i = 0; i < NA; i++) begin m_en[i] = 0; m_amin[i] = 0; end
    end else begin
      sh  = int'(set_val[23:20]) * 10 + int'(set_val[19:16]);
      smn = int'(set_val[15:12]) * 10 + int'(set_val[11:8]);
      ss  = int'(set_val[7:4]) * 10 + int'(set_val[3:0]);
      dig_ok = (set_val[19:16] <= 9) && (set_val[11:8] <= 9) && (set_val[3:0] <= 9) &&
               (set_val[15:12] <= 5) && (set_val[7:4] <= 5) && (sh <= 23);
      set_ok = set_time && dig_ok;
      adv    = !set_ok && (m_pre == TPS - 1);
      nsec   = (m_sec + 1) % 86400;
      win    = -1;
      for (int i = 0; i < NA; i++)
        if (win < 0 && m_en[i] && m_amin[i] == nsec / 60) win = i;
      match = adv && (nsec % 60 == 0) && (win >= 0);
      case (m_mode)
        0: if (match) begin m_mode = 1; m_id = win; m_rt = RS; end
        1: begin
          if (dismiss) m_mode = 0;
          else if (snooze) begin m_mode = 2; m_st = SM * 60; end
          else if (adv) begin m_rt--; if (m_rt == 0) m_mode = 0; end
        end
        default: begin
          if (dismiss) m_mode = 0;
          else if (adv) begin m_st--; if (m_st == 0) begin m_mode = 1; m_rt = RS; end end
        end
      endcase
      ah = int'(alm_val[15:12]) * 10 + int'(alm_val[11:8]);
      am = int'(alm_val[7:4]) * 10 + int'(alm_val[3:0]);
      if (alm_wr && alm_val[11:8] <= 9 && alm_val[3:0] <= 9 && alm_val[7:4] <= 5 && ah <= 23 &&
          int'(alm_idx) < NA) begin
        m_en[alm_idx]   = alm_val[16];
        m_amin[alm_idx] = ah * 60 + am;
      end
      if (set_ok) begin m_sec = sh * 3600 + smn * 60 + ss; m_pre = 0; end
      else if (adv) begin m_sec = nsec; m_pre = 0; end
      else m_pre++;
      m_tick = adv;
    end
  endtask

  task automatic check_all();
    int h, mi, s, dh;
    bit epm;
    h = m_sec / 3600; mi = (m_sec / 60) % 60; s = m_sec % 60;
    if (mode12) begin dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h); epm = (h >= 12); end
    else begin dh = h; epm = 0; end
    chk("secU", secU, s % 10);         chk("secT", secT, s / 10);
    chk("minU", minU, mi % 10);        chk("minT", minT, mi / 10);
    chk("hrU", hrU, dh % 10);          chk("hrT", hrT, dh / 10);
    chk("secUSeg", secUSeg, seg_tab[s % 10]);  chk("secTSeg", secTSeg, seg_tab[s / 10]);
    chk("minUSeg", minUSeg, seg_tab[mi % 10]); chk("minTSeg", minTSeg, seg_tab[mi / 10]);
    chk("hrUSeg", hrUSeg, seg_tab[dh % 10]);   chk("hrTSeg", hrTSeg, seg_tab[dh / 10]);
    chk("pm", pm, epm);
    chk("tick", tick, m_tick);
    chk("ringing", ringing, (m_mode == 1));
    chk("ring_id", ring_id, m_id);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    set_time = 1'b0;
    alm_wr   = 1'b0;
    check_all();
  endtask

  task automatic set_clock(input logic [23:0] v);
    set_time = 1'b1; set_val = v;
    cyc();
  endtask

  task automatic write_alarm(input logic [1:0] idx, input logic [16:0] v);
    alm_wr = 1'b1; alm_idx = idx; alm_val = v;
    cyc();
  endtask

  task automatic run_ticks(input int n);
    int c;
    for (int k = 0; k < n; k++) begin
      c = 0;
      do begin cyc(); c++; end while (tick !== 1'b1 && c < TPS + 2);
      chk("tick_wait", tick, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, mn, nc;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    reset = 1'b1; set_time = 1'b0; set_val = 24'h0; alm_wr = 1'b0; alm_idx = 2'd0;
    alm_val = 17'h0; snooze = 1'b0; dismiss = 1'b0; mode12 = 1'b0;

    cur_tag = "reset";
    cyc();
    reset = 1'b0;
    chk("seg_all", {secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg}, {6{7'h3F}});
    mode12 = 1'b1; #1;
    check_all();
    chk("hrT12", hrT, 1); chk("hrU12", hrU, 2);
    chk("hrTSeg12", hrTSeg, 7'h06); chk("hrUSeg12", hrUSeg, 7'h5B); chk("pm12", pm, 0);
    mode12 = 1'b0;

    cur_tag = "first_tick";
    repeat (4) cyc();
    chk("tick", tick, 1); chk("secU", secU, 1); chk("secUSeg", secUSeg, 7'h06);

    cur_tag = "day_wrap";
    set_clock(24'h235959);
    run_ticks(1);
    chk("hms", {hrT, hrU, minT, minU, secT, secU}, 24'h000000);

    cur_tag = "bad_load";
    set_clock(24'h123456);
    set_clock(24'h240000);
    set_clock(24'h126000);
    chk("hms", {hrT, hrU, minT, minU, secT, secU}, 24'h123456);

    cur_tag = "load_on_tick";
    for (int k = 0; k < TPS + 1 && m_pre != TPS - 1; k++) cyc();
    set_clock(24'h101010);
    chk("tick", tick, 0);
    chk("hms", {hrT, hrU, minT, minU, secT, secU}, 24'h101010);

    cur_tag = "ring_prio";
    write_alarm(2'd0, 17'h1_0001);
    write_alarm(2'd2, 17'h1_0001);
    set_clock(24'h000059);
    run_ticks(1);
    chk("ringing", ringing, 1); chk("ring_id", ring_id, 0);
    run_ticks(3);
    chk("ring_stop", ringing, 0);

    cur_tag = "snooze";
    set_clock(24'h000059);
    run_ticks(1);
    chk("ringing", ringing, 1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snoozed", ringing, 0);
    run_ticks(60);
    chk("reringing", ringing, 1); chk("ring_id", ring_id, 0);
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    chk("dismissed", ringing, 0);
    run_ticks(65);

    cur_tag = "mode12";
    mode12 = 1'b1;
    set_clock(24'h130500);
    chk("hrT", hrT, 0); chk("hrU", hrU, 1); chk("pm", pm, 1);
    set_clock(24'h003000);
    chk("hrT", hrT, 1); chk("hrU", hrU, 2); chk("pm", pm, 0);
    mode12 = 1'b0;

    cur_tag = "reset_mid_ring";
    set_clock(24'h000059);
    run_ticks(1);
    chk("ringing", ringing, 1);
    reset = 1'b1; snooze = 1'b1; set_time = 1'b1; set_val = 24'h120000;
    alm_wr = 1'b1; alm_idx = 2'd1; alm_val = 17'h1_0001;
    cyc();
    reset = 1'b0; snooze = 1'b0;
    chk("ringing", ringing, 0);
    chk("hms", {hrT, hrU, minT, minU, secT, secU}, 24'h000000);
    run_ticks(61);
    chk("no_ring", ringing, 0);

    cur_tag = "random";
    for (int r = 0; r < 40; r++) begin
      h = int'($urandom_range(23)); mn = int'($urandom_range(58));
      if ($urandom_range(9) == 0) write_alarm(2'($urandom_range(3)), 17'($urandom));
      else write_alarm(2'($urandom_range(3)), {1'($urandom_range(3) != 0), bcd(h), bcd(mn + 1)});
      mode12 = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) set_clock(24'($urandom));
      else set_clock({bcd(h), bcd(mn), bcd(int'($urandom_range(55, 59)))});
      nc = int'($urandom_range(40, 120));
      for (int k = 0; k < nc; k++) begin
        snooze  = ($urandom_range(15) == 0);
        dismiss = ($urandom_range(30) == 0);
        if ($urandom_range(25) == 0) begin
          set_time = 1'b1;
          set_val  = {bcd(int'($urandom_range(23))), bcd(int'($urandom_range(59))),
                      bcd(int'($urandom_range(59)))};
        end
        cyc();
      end
      snooze = 1'b0; dismiss = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, clk cycles per second.
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of independent alarm slots (1..16).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-004 SHALL have parameter RING_SEC, default 60, auto-stop ring length in seconds (1..255).
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port set_time  in  1  one-cycle pulse, load set_val into time.
REQ-008 SHALL have port set_val  in  24  BCD {hrT,hrU,minT,minU,secT,secU}.
REQ-009 SHALL have port alm_wr  in  1  one-cycle pulse, write alarm slot.
REQ-010 SHALL have port alm_idx  in  max(1,clog2(NUM_ALARMS))  slot index.
REQ-011 SHALL have port alm_val  in  17  {enable, hrT, hrU, minT, minU} BCD.
REQ-012 SHALL have ports snooze, dismiss  in  1 each  level, sampled per cycle.
REQ-013 SHALL have port mode12  in  1  1 = 12-hour display format.
REQ-014 SHALL have ports secU, secT, minU, minT, hrU, hrT  out  4 each  displayed BCD digits.
REQ-015 SHALL have ports secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg  out  7 each  active-high segments {g,f,e,d,c,b,a}.
REQ-016 SHALL have ports pm  out  1, tick  out  1, ringing  out  1, ring_id  out  width of alm_idx.

Function
REQ-017 Prescaler SHALL count 0..TICKS_PER_SEC-1; tick SHALL pulse one cycle, registered, in the cycle time advances.
REQ-018 Time SHALL be kept internally as 24-hour BCD; each tick advances one second with BCD carries; 23:59:59 wraps to 00:00:00.
REQ-019 set_time SHALL load set_val next cycle and clear prescaler to 0 only if valid (units<=9, secT/minT<=5, hours<=23); invalid loads SHALL be ignored entirely.
REQ-020 set_time SHALL take priority over a tick in the same cycle; no tick pulse and no alarm match that cycle.
REQ-021 alm_wr SHALL store alm_val in slot alm_idx if hours<=23, minT<=5, units<=9, else ignore; out-of-range alm_idx SHALL be ignored.
REQ-022 A match SHALL occur only on a tick producing time HH:MM:00 equal to an enabled slot; lowest-index matching slot wins.
REQ-023 FSM states IDLE, RINGING, SNOOZE; ringing=1 only in RINGING.
REQ-024 IDLE->RINGING on match; ring_id SHALL latch winning slot; ring timer loads RING_SEC.
REQ-025 RINGING: dismiss->IDLE; else snooze->SNOOZE with countdown SNOOZE_MIN*60 s; else ring timer reaching 0 on a tick->IDLE.
REQ-026 SNOOZE: dismiss->IDLE; countdown reaching 0 on a tick->RINGING, ring timer reloaded, ring_id unchanged.
REQ-027 dismiss SHALL beat snooze when both asserted; matches in RINGING/SNOOZE SHALL be ignored.
REQ-028 Alarm writes and set_time SHALL NOT alter FSM state or ring_id.
REQ-029 mode12=0: digits equal internal time, pm=0; mode12=1: hour 00->12 pm=0, 01-11 unchanged pm=0, 12 pm=1, 13-23 minus 12 pm=1; leading zero shown.
REQ-030 Segment map SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, others 00; digit and segment outputs combinational from registered state.

Reset
REQ-031 reset SHALL, next edge, set time 00:00:00, prescaler 0, all slots 00:00 disabled, FSM IDLE, ringing 0, ring_id 0, tick 0, timers 0.
REQ-032 After reset with mode12=0 all segments SHALL be 3F; with mode12=1 hrT=1, hrU=2, hrTSeg=06, hrUSeg=5B, pm=0.
REQ-033 reset SHALL override set_time, alm_wr, snooze, dismiss in the same cycle, including mid-ring.

Verification (TICKS_PER_SEC=4, SNOOZE_MIN=1, RING_SEC=3)
REQ-034 Reset, run 4 cycles -> tick once, secU=1, secUSeg=06; load 23:59:59 then one tick -> 00:00:00.
REQ-035 set_time 24:00:00 or 12:60:00 -> time unchanged; set_time coincident with tick -> value loaded, tick=0.
REQ-036 Slots 0 and 2 both 00:01 enabled, load 00:00:59, one tick -> ringing=1, ring_id=0; 3 further ticks -> IDLE.
REQ-037 Ringing, pulse snooze -> ringing=0; 60 ticks later -> ringing=1, ring_id unchanged; snooze+dismiss together -> IDLE.
REQ-038 mode12=1 at 13:05:00 -> hrT=0, hrU=1, pm=1; at 00:30:00 -> hrT=1, hrU=2, pm=0.
REQ-039 Assert reset while RINGING -> ringing=0, time 00:00:00, alarms disabled; next 00:01 crossing -> no ring.
